tone_gen: RTL and testbench

TONE_GEN -- requirements
Module: tone_gen

---
 rtl/tone_gen.sv | 125 ++++++++++++
 tb/tb_tone_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tone_gen.sv
// Square-wave tone generator: plays note codes 1-8 (C4..C5) on the speaker pin.
// Note changes only take effect at full-period boundaries; mute and RESET cut immediately.
module tone_gen #(
  parameter int unsigned OCTAVE_SHIFT = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] note,
  input  logic       mute,
  output logic       speaker,
  output logic       active,
  output logic [3:0] cur_note
);

  typedef enum logic {
    IDLE,
    TONE
  } state_t;

  state_t      state, state_n;
  logic [3:0]  note_q;
  logic [17:0] half_q, half_n;
  logic [17:0] cnt, cnt_n;
  logic        speaker_n, active_n;
  logic [3:0]  cur_note_n;
  logic        note_ok;
  logic [17:0] note_half;
  logic        half_end;

  function automatic logic [17:0] half_lookup(input logic [3:0] code);
    logic [17:0] base;
    case (code)
      4'd1:    base = 18'd191110;
      4'd2:    base = 18'd170265;
      4'd3:    base = 18'd151685;
      4'd4:    base = 18'd143172;
      4'd5:    base = 18'd127551;
      4'd6:    base = 18'd113636;
      4'd7:    base = 18'd101239;
      4'd8:    base = 18'd95557;
      default: base = '0;
    endcase
    return base >> OCTAVE_SHIFT;
  endfunction

  assign note_ok   = (note_q != 4'd0) && (note_q <= 4'd8);
  assign note_half = half_lookup(note_q);
  assign half_end  = (cnt == 18'(half_q - 18'd1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      note_q   <= '0;
      half_q   <= '0;
      cnt      <= '0;
      speaker  <= 1'b0;
      active   <= 1'b0;
      cur_note <= '0;
    end else begin
      state    <= state_n;
      note_q   <= note;
      half_q   <= half_n;
      cnt      <= cnt_n;
      speaker  <= speaker_n;
      active   <= active_n;
      cur_note <= cur_note_n;
    end
  end

  always_comb begin
    state_n    = state;
    half_n     = half_q;
    cnt_n      = cnt;
    speaker_n  = speaker;
    active_n   = active;
    cur_note_n = cur_note;

    if (mute) begin
      state_n    = IDLE;
      cnt_n      = '0;
      speaker_n  = 1'b0;
      active_n   = 1'b0;
      cur_note_n = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n      = '0;
          speaker_n  = 1'b0;
          active_n   = 1'b0;
          cur_note_n = '0;
          if (note_ok) begin
            state_n    = TONE;
            half_n     = note_half;
            cur_note_n = note_q;
            speaker_n  = 1'b1;
            active_n   = 1'b1;
          end
        end
        TONE: begin
          if (!half_end) begin
            cnt_n = cnt + 18'd1;
          end else begin
            cnt_n = '0;
            if (speaker) begin
              speaker_n = 1'b0;
            end else if (note_q == cur_note) begin
              speaker_n = 1'b1;
            end else if (note_ok) begin
              half_n     = note_half;
              cur_note_n = note_q;
              speaker_n  = 1'b1;
            end else begin
              // End of a low half with no valid note: rest, never a partial period
              state_n    = IDLE;
              speaker_n  = 1'b0;
              active_n   = 1'b0;
              cur_note_n = '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen at OCTAVE_SHIFT=3: expected speaker edges are queued
// by the stimulus and popped by a monitor on every observed speaker transition.
module tb_tone_gen;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  logic       mute  = 1'b0;
  logic [3:0] note  = 4'd0;
  logic       speaker;
  logic       active;
  logic [3:0] cur_note;

  tone_gen #(.OCTAVE_SHIFT(3)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .note    (note),
    .mute    (mute),
    .speaker (speaker),
    .active  (active),
    .cur_note(cur_note)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       lvl;
    int         len;
    int         at;
    logic       act;
    logic [3:0] cn;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   compared = 0;
  int   failed   = 0;

  localparam int H1 = 23888;  // C4: 191110 >> 3
  localparam int H8 = 11944;  // C5: 95557 >> 3

  task automatic chk(input string nm, input int got, input int want);
    compared++;
    if (got != want) begin
      failed++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  // len / at of 0 mean "don't care"
  task automatic expect_edge(input logic lvl, input int len, input int at,
                             input logic act, input logic [3:0] cn);
    exp_t e;
    e.lvl = lvl;
    e.len = len;
    e.at  = at;
    e.act = act;
    e.cn  = cn;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   r, r2, r3, r5, n, b, nedge;
    exp_t left;

    fork
      begin : monitor
        logic prev_spk;
        int   last_chg;
        int   len;
        exp_t e;
        prev_spk = 1'b0;
        last_chg = 0;
        nedge    = 0;
        forever begin
          @(posedge CLK);
          cyc++;
          #1;
          if (speaker !== prev_spk) begin
            compared++;
            nedge++;
            len = cyc - last_chg;
            if (exp_q.size() == 0) begin
              failed++;
              $display("FAIL unexpected_edge: speaker went %0b at cyc %0d, want no transition",
                       speaker, cyc);
            end else begin
              e = exp_q.pop_front();
              if (speaker !== e.lvl || active !== e.act || cur_note !== e.cn ||
                  (e.len != 0 && len != e.len) || (e.at != 0 && cyc != e.at)) begin
                failed++;
                $display("FAIL edge_%0d: got lvl=%0b len=%0d cyc=%0d active=%0b cur_note=%0d, want lvl=%0b len=%0d at=%0d active=%0b cur_note=%0d (0=any for len/at)",
                         nedge, speaker, len, cyc, active, cur_note,
                         e.lvl, e.len, e.at, e.act, e.cn);
              end
            end
            prev_spk = speaker;
            last_chg = cyc;
          end
        end
      end
    join_none

    // Asynchronous reset from power-up
    #3 RESET = 1'b1;
    #1;
    chk("reset_speaker", int'(speaker), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_cur_note", int'(cur_note), 0);
    wait_cyc(3);
    RESET = 1'b0;

    // Invalid code stays silent
    note = 4'd12;
    n = cyc;
    wait_cyc(n + 1000);
    chk("invalid_speaker", int'(speaker), 0);
    chk("invalid_active", int'(active), 0);
    chk("invalid_cur_note", int'(cur_note), 0);

    // C4 from idle: rise two edges later; mute at counter 100 of the high half
    note = 4'd1;
    n = cyc;
    r = n + 2;
    expect_edge(1'b1, 0, r, 1'b1, 4'd1);
    wait_cyc(r + 100);
    chk("tone_active", int'(active), 1);
    chk("tone_cur_note", int'(cur_note), 1);
    mute = 1'b1;
    expect_edge(1'b0, 101, r + 101, 1'b0, 4'd0);
    wait_cyc(r + 101);
    mute = 1'b0;
    chk("mute_active", int'(active), 0);
    chk("mute_cur_note", int'(cur_note), 0);

    // Restart with a full C4 period; switch to C5 mid-high, honoured only at the boundary
    r2 = r + 102;
    expect_edge(1'b1, 1, r2, 1'b1, 4'd1);
    expect_edge(1'b0, H1, r2 + H1, 1'b1, 4'd1);
    wait_cyc(r2 + 100);
    note = 4'd8;
    r3 = r2 + 2 * H1;
    expect_edge(1'b1, H1, r3, 1'b1, 4'd8);
    wait_cyc(r3 - 1);
    chk("pre_switch_cur_note", int'(cur_note), 1);

    // C5: short glitch to none and back must not disturb the waveform
    wait_cyc(r3 + 100);
    note = 4'd0;
    wait_cyc(r3 + 105);
    note = 4'd8;
    expect_edge(1'b0, H8, r3 + H8, 1'b1, 4'd8);

    // Note released during the low half: period completes, then rest
    wait_cyc(r3 + H8 + 100);
    note = 4'd0;
    b = r3 + 2 * H8;
    wait_cyc(b - 1);
    chk("pre_rest_active", int'(active), 1);
    chk("pre_rest_cur_note", int'(cur_note), 8);
    wait_cyc(b);
    chk("rest_active", int'(active), 0);
    chk("rest_cur_note", int'(cur_note), 0);
    chk("rest_speaker", int'(speaker), 0);

    // RESET mid high half cuts the tone without a clock edge
    wait_cyc(b + 10);
    note = 4'd8;
    n = cyc;
    r5 = n + 2;
    expect_edge(1'b1, 0, r5, 1'b1, 4'd8);
    wait_cyc(r5 + 100);
    #1 RESET = 1'b1;
    #1;
    chk("async_reset_speaker", int'(speaker), 0);
    chk("async_reset_cur_note", int'(cur_note), 0);
    chk("async_reset_active", int'(active), 0);
    expect_edge(1'b0, 0, r5 + 101, 1'b0, 4'd0);
    wait_cyc(r5 + 103);
    RESET = 1'b0;
    expect_edge(1'b1, 0, r5 + 105, 1'b1, 4'd8);
    wait_cyc(r5 + 105 + 200);
    chk("final_active", int'(active), 1);
    chk("final_cur_note", int'(cur_note), 8);

    while (exp_q.size() > 0) begin
      left = exp_q.pop_front();
      compared++;
      failed++;
      $display("FAIL missing_edge: got no transition, want lvl=%0b at=%0d cur_note=%0d",
               left.lvl, left.at, left.cn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
